// File: rtl/neuron_batch_feeder.sv
// neuron_batch_feeder: buffers one raster-order frame from a valid/ready pixel
// stream and replays it as BATCH_SIZE beats of NUM_LANES parallel pixel lanes.
// Lane i of beat b carries pixel i*BATCH_SIZE+b; out_beat doubles as the
// weight-memory address downstream.
// Optional build macro NEURON_FEEDER_PINGPONG_EN: two frame banks, so the next
// frame loads while the current one streams. Undefined: single bank, and the
// loader stalls for the whole stream.
module neuron_batch_feeder #(
  parameter int unsigned NUM_INPUTS  = 784,
  parameter int unsigned PIXEL_WIDTH = 10,
  parameter int unsigned NUM_LANES   = 16,
  parameter int unsigned BATCH_SIZE  = 49,
  parameter int unsigned BEAT_WIDTH  = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PIXEL_WIDTH-1:0]           in_pixel,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [NUM_LANES*PIXEL_WIDTH-1:0] out_pixels,
  output logic [BEAT_WIDTH-1:0]            out_beat,
  output logic                             out_first,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             frame_done
);

`ifdef NEURON_FEEDER_PINGPONG_EN
  localparam int unsigned NUM_BANKS = 2;
`else
  localparam int unsigned NUM_BANKS = 1;
`endif
  localparam int unsigned LOAD_W    = $clog2(NUM_INPUTS);
  localparam int unsigned BUF_DEPTH = NUM_BANKS * NUM_INPUTS;
  localparam int unsigned ADDR_W    = $clog2(BUF_DEPTH);
  localparam int unsigned BUS_W     = NUM_LANES * PIXEL_WIDTH;

  typedef enum logic {S_LOAD = 1'b0, S_STREAM = 1'b1} state_t;

  state_t                  r_state;
  logic [LOAD_W-1:0]       r_load_cnt;
  logic [BEAT_WIDTH-1:0]   r_beat_cnt;
  logic                    r_load_bank;
  logic                    r_stream_bank;
  logic [1:0]              r_full;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_out_first;
  logic                    r_out_last;
  logic                    r_frame_done;
  logic [BUS_W-1:0]        r_out_pixels;
  logic [PIXEL_WIDTH-1:0]  r_buf [BUF_DEPTH];

  state_t                  w_state_nxt;
  logic                    w_in_fire;
  logic                    w_load_done;
  logic                    w_out_fire;
  logic                    w_beat_done;
  logic                    w_start;
  logic [1:0]              w_full_nxt;
  logic                    w_load_bank_nxt;
  logic                    w_stream_bank_nxt;
  logic [LOAD_W-1:0]       w_load_cnt_nxt;
  logic [BEAT_WIDTH-1:0]   w_beat_cnt_nxt;
  logic [ADDR_W-1:0]       w_wr_addr;
  logic [ADDR_W-1:0]       w_rd_base;
  logic                    w_rd_en;
  logic [BUS_W-1:0]        w_pix_nxt;
  logic                    w_valid_nxt;
  logic                    w_first_nxt;
  logic                    w_last_nxt;
  logic                    w_in_ready_nxt;

  // Next-state, bank bookkeeping, counters and next beat payload.
  always_comb begin
    w_state_nxt       = r_state;
    w_full_nxt        = r_full;
    w_load_bank_nxt   = 1'b0;
    w_stream_bank_nxt = 1'b0;
    w_load_cnt_nxt    = r_load_cnt;
    w_beat_cnt_nxt    = r_beat_cnt;
    w_pix_nxt         = r_out_pixels;

    w_in_fire   = in_valid && r_in_ready;
    w_load_done = w_in_fire && (r_load_cnt == LOAD_W'(NUM_INPUTS - 1));
    w_out_fire  = r_out_valid && out_ready;
    w_beat_done = w_out_fire && (r_beat_cnt == BEAT_WIDTH'(BATCH_SIZE - 1));

    if (w_in_fire) begin
      w_load_cnt_nxt = w_load_done ? '0 : r_load_cnt + LOAD_W'(1);
    end

    if (w_load_done) w_full_nxt[r_load_bank]   = 1'b1;
    if (w_beat_done) w_full_nxt[r_stream_bank] = 1'b0;

`ifdef NEURON_FEEDER_PINGPONG_EN
    w_load_bank_nxt   = w_load_done ? ~r_load_bank   : r_load_bank;
    w_stream_bank_nxt = w_beat_done ? ~r_stream_bank : r_stream_bank;
`endif

    // A full bank (including one completing this cycle) starts once the streamer frees up.
    w_start = ((r_state == S_LOAD) || w_beat_done) && w_full_nxt[w_stream_bank_nxt];

    if (w_start) begin
      w_state_nxt = S_STREAM;
    end else if (w_beat_done) begin
      w_state_nxt = S_LOAD;
    end

    if (w_start || w_beat_done) begin
      w_beat_cnt_nxt = '0;
    end else if (w_out_fire) begin
      w_beat_cnt_nxt = r_beat_cnt + BEAT_WIDTH'(1);
    end

    w_wr_addr = ADDR_W'(r_load_cnt) + (r_load_bank ? ADDR_W'(NUM_INPUTS) : '0);
    w_rd_base = w_stream_bank_nxt ? ADDR_W'(NUM_INPUTS) : '0;
    w_rd_en   = w_start || (w_out_fire && !w_beat_done);
    if (w_rd_en) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        w_pix_nxt[i*PIXEL_WIDTH +: PIXEL_WIDTH] =
          r_buf[w_rd_base + ADDR_W'(i * BATCH_SIZE) + ADDR_W'(w_beat_cnt_nxt)];
      end
    end

    w_valid_nxt    = (w_state_nxt == S_STREAM);
    w_first_nxt    = w_valid_nxt && (w_beat_cnt_nxt == '0);
    w_last_nxt     = w_valid_nxt && (w_beat_cnt_nxt == BEAT_WIDTH'(BATCH_SIZE - 1));
    w_in_ready_nxt = !w_full_nxt[w_load_bank_nxt];
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_LOAD;
      r_load_cnt    <= '0;
      r_beat_cnt    <= '0;
      r_load_bank   <= 1'b0;
      r_stream_bank <= 1'b0;
      r_full        <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_first   <= 1'b0;
      r_out_last    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_out_pixels  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_load_cnt    <= w_load_cnt_nxt;
      r_beat_cnt    <= w_beat_cnt_nxt;
      r_load_bank   <= w_load_bank_nxt;
      r_stream_bank <= w_stream_bank_nxt;
      r_full        <= w_full_nxt;
      r_in_ready    <= w_in_ready_nxt;
      r_out_valid   <= w_valid_nxt;
      r_out_first   <= w_first_nxt;
      r_out_last    <= w_last_nxt;
      r_frame_done  <= w_beat_done;
      r_out_pixels  <= w_pix_nxt;
    end
  end

  // Frame storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_buf[w_wr_addr] <= in_pixel;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_pixels = r_out_pixels;
  assign out_beat   = r_beat_cnt;
  assign out_first  = r_out_first;
  assign out_last   = r_out_last;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_neuron_batch_feeder.sv
// Bench for neuron_batch_feeder: scoreboard of expected beats built from the
// pixel pattern, compared against beats captured on each output handshake.
module tb_neuron_batch_feeder;
  localparam int NPIX  = 784;
  localparam int PW    = 10;
  localparam int LANES = 16;
  localparam int BATCH = 49;
  localparam int BW    = 6;

  typedef struct packed {
    logic [LANES*PW-1:0] pix;
    logic [BW-1:0]       beat;
    logic                first;
    logic                last;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [PW-1:0]       in_pixel;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*PW-1:0] out_pixels;
  logic [BW-1:0]       out_beat;
  logic                out_first;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;
  logic                frame_done;

  neuron_batch_feeder dut (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(in_ready), .out_pixels(out_pixels), .out_beat(out_beat),
    .out_first(out_first), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_pass = 0;
  int    n_total = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    first_q[$];

  int g_acc, g_t_acc, g_valid_early;
  int g_fd, g_fd_bad, g_last_cyc, g_stall_seen, g_unstable;
  int g_inready_hi, g_inready_lo_f1, g_drain_ok;
  logic g_fd_valid, g_fd_inready;

  function automatic logic [PW-1:0] pix_of(input int kind, input int k);
    return (kind == 0) ? PW'(k) : PW'(1023 - k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: lane i of beat b is pixel i*BATCH+b.
  task automatic push_exp(input int kind);
    for (int b = 0; b < BATCH; b++) begin
      beat_t e;
      e.pix = '0;
      for (int i = 0; i < LANES; i++) e.pix[i*PW +: PW] = pix_of(kind, i*BATCH + b);
      e.beat  = BW'(b);
      e.first = (b == 0);
      e.last  = (b == BATCH - 1);
      exp_q.push_back(e);
    end
  endtask

  // Drives n_pix pixels of pattern kind at the given valid duty (percent).
  task automatic load_frame(input int kind, input int n_pix, input int duty);
    int   budget;
    logic fire;
    budget = 6000;
    g_acc = 0;
    g_valid_early = 0;
    while (g_acc < n_pix && budget > 0) begin
      if (out_valid) g_valid_early++;
      in_valid = ($urandom_range(0, 99) < duty);
      in_pixel = pix_of(kind, g_acc);
      fire = in_valid && in_ready;
      if (fire) g_t_acc = cyc;
      tick();
      if (fire) g_acc++;
      budget--;
    end
    in_valid = 1'b0;
  endtask

  // Consumes n_frames frames, optionally stalling at stall_beat, recording beats and events.
  task automatic drain(input int stall_beat, input int stall_len, input int n_frames);
    int budget, lasts, after, stall_left;
    logic [LANES*PW+BW+1:0] snap, cur;
    budget = 4000; lasts = 0; after = 0; stall_left = stall_len; snap = '0;
    g_fd = 0; g_fd_bad = 0; g_last_cyc = -1; g_stall_seen = 0; g_unstable = 0;
    g_inready_hi = 0; g_inready_lo_f1 = 0; g_fd_valid = 1'bx; g_fd_inready = 1'bx;
    first_q.delete();
    while (budget > 0 && !(lasts == n_frames && after >= 3)) begin
      if (frame_done) begin
        g_fd++;
        if (cyc != g_last_cyc + 1) g_fd_bad++;
        g_fd_valid = out_valid;
        g_fd_inready = in_ready;
      end
      if (out_valid && in_ready) g_inready_hi++;
      if (out_valid && !in_ready && lasts == 0) g_inready_lo_f1++;
      out_ready = 1'b1;
      if (out_valid && int'(out_beat) == stall_beat) begin
        cur = {out_pixels, out_beat, out_first, out_last};
        if (g_stall_seen > 0 && cur !== snap) g_unstable++;
        if (stall_left > 0) begin
          if (g_stall_seen == 0) snap = cur;
          out_ready = 1'b0;
          stall_left--;
          g_stall_seen++;
        end
      end
      if (out_valid && out_ready) begin
        obs_q.push_back('{pix: out_pixels, beat: out_beat, first: out_first, last: out_last});
        if (out_first) first_q.push_back(cyc);
        if (out_last) begin
          lasts++;
          g_last_cyc = cyc;
        end
      end
      if (lasts == n_frames) after++;
      tick();
      budget--;
    end
    g_drain_ok = (lasts == n_frames && after >= 3) ? 1 : 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_first !== 1'b0) $display("FAIL reset out_first: got %b want 0", out_first); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL reset out_last: got %b want 0", out_last); else n_pass++;
    n_total++; if (frame_done !== 1'b0) $display("FAIL reset frame_done: got %b want 0", frame_done); else n_pass++;
    n_total++; if (out_beat !== '0) $display("FAIL reset out_beat: got %0d want 0", out_beat); else n_pass++;
    n_total++; if (out_pixels !== '0) $display("FAIL reset out_pixels: got %h want 0", out_pixels); else n_pass++;
  endtask

  task automatic test_basic();
    beat_t e, o;
    push_exp(0);
    load_frame(0, NPIX, 100);
    n_total++; if (g_acc != NPIX) $display("FAIL basic accepted: got %0d want %0d", g_acc, NPIX); else n_pass++;
    n_total++; if (g_valid_early != 0) $display("FAIL basic early out_valid: got %0d cycles want 0", g_valid_early); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic latency out_valid: got %b want 1", out_valid); else n_pass++;
    drain(-1, 0, 1);
    n_total++; if (g_drain_ok != 1) $display("FAIL basic drain timeout: got %0d want 1", g_drain_ok); else n_pass++;
    n_total++; if (g_fd != 1) $display("FAIL basic frame_done pulses: got %0d want 1", g_fd); else n_pass++;
    n_total++; if (g_fd_bad != 0) $display("FAIL basic frame_done timing: got %0d misplaced want 0", g_fd_bad); else n_pass++;
    n_total++; if (g_fd_valid !== 1'b0) $display("FAIL basic out_valid at done: got %b want 0", g_fd_valid); else n_pass++;
    n_total++; if (g_fd_inready !== 1'b1) $display("FAIL basic in_ready at done: got %b want 1", g_fd_inready); else n_pass++;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL basic beat count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL basic beat %0d: got beat=%0d f=%b l=%b pix=%h want beat=%0d f=%b l=%b pix=%h", e.beat, o.beat, o.first, o.last, o.pix, e.beat, e.first, e.last, e.pix);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    beat_t e, o;
    push_exp(0);
    load_frame(0, NPIX, 100);
    drain(10, 5, 1);
    n_total++; if (g_stall_seen != 5) $display("FAIL bp stall cycles: got %0d want 5", g_stall_seen); else n_pass++;
    n_total++; if (g_unstable != 0) $display("FAIL bp held outputs changed: got %0d cycles want 0", g_unstable); else n_pass++;
    n_total++; if (g_fd != 1) $display("FAIL bp frame_done pulses: got %0d want 1", g_fd); else n_pass++;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL bp beat count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL bp beat %0d: got beat=%0d f=%b l=%b pix=%h want beat=%0d f=%b l=%b pix=%h", e.beat, o.beat, o.first, o.last, o.pix, e.beat, e.first, e.last, e.pix);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random_valid();
    beat_t e, o;
    push_exp(0);
    load_frame(0, NPIX, 50);
    n_total++; if (g_acc != NPIX) $display("FAIL rand accepted: got %0d want %0d", g_acc, NPIX); else n_pass++;
    n_total++; if (g_valid_early != 0) $display("FAIL rand early out_valid: got %0d cycles want 0", g_valid_early); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL rand latency out_valid: got %b want 1", out_valid); else n_pass++;
    drain(-1, 0, 1);
`ifndef NEURON_FEEDER_PINGPONG_EN
    n_total++; if (g_inready_hi != 0) $display("FAIL rand in_ready during stream: got %0d cycles want 0", g_inready_hi); else n_pass++;
`endif
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL rand beat count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL rand beat %0d: got beat=%0d f=%b l=%b pix=%h want beat=%0d f=%b l=%b pix=%h", e.beat, o.beat, o.first, o.last, o.pix, e.beat, e.first, e.last, e.pix);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_load();
    beat_t e, o;
    logic [PW-1:0] lane0;
    load_frame(0, 400, 100);
    n_total++; if (g_acc != 400) $display("FAIL rstload partial accepted: got %0d want 400", g_acc); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rstload in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rstload out_valid: got %b want 0", out_valid); else n_pass++;
    push_exp(1);
    load_frame(1, NPIX, 100);
    n_total++; if (out_valid !== 1'b1) $display("FAIL rstload latency out_valid: got %b want 1", out_valid); else n_pass++;
    drain(-1, 0, 1);
    lane0 = (obs_q.size() > 0) ? obs_q[0].pix[PW-1:0] : 'x;
    n_total++; if (lane0 !== 10'd1023) $display("FAIL rstload beat0 lane0: got %0d want 1023", lane0); else n_pass++;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL rstload beat count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL rstload beat %0d: got beat=%0d f=%b l=%b pix=%h want beat=%0d f=%b l=%b pix=%h", e.beat, o.beat, o.first, o.last, o.pix, e.beat, e.first, e.last, e.pix);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_stream();
    beat_t e, o;
    int guard, fd_seen, valid_seen;
    load_frame(0, NPIX, 100);
    out_ready = 1'b1;
    guard = 100;
    while (!(out_valid === 1'b1 && out_beat == BW'(20)) && guard > 0) begin
      tick();
      guard--;
    end
    n_total++; if (out_beat !== BW'(20)) $display("FAIL rststream reach beat 20: got %0d want 20", out_beat); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rststream out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_beat !== '0) $display("FAIL rststream out_beat: got %0d want 0", out_beat); else n_pass++;
    fd_seen = (frame_done === 1'b1) ? 1 : 0;
    valid_seen = 0;
    repeat (60) begin
      tick();
      if (frame_done === 1'b1) fd_seen++;
      if (out_valid === 1'b1) valid_seen++;
    end
    n_total++; if (fd_seen != 0) $display("FAIL rststream frame_done pulses: got %0d want 0", fd_seen); else n_pass++;
    n_total++; if (valid_seen != 0) $display("FAIL rststream stale beats: got %0d want 0", valid_seen); else n_pass++;
    push_exp(0);
    load_frame(0, NPIX, 100);
    drain(-1, 0, 1);
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL rststream beat count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL rststream beat %0d: got beat=%0d f=%b l=%b pix=%h want beat=%0d f=%b l=%b pix=%h", e.beat, o.beat, o.first, o.last, o.pix, e.beat, e.first, e.last, e.pix);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    beat_t e, o;
    int acc_a, acc_b, t_b, f2;
    push_exp(0);
    push_exp(1);
    fork
      begin
        load_frame(0, NPIX, 100);
        acc_a = g_acc;
        load_frame(1, NPIX, 100);
        acc_b = g_acc;
        t_b = g_t_acc;
      end
      drain(-1, 0, 2);
    join
    n_total++; if (acc_a != NPIX) $display("FAIL b2b frame1 accepted: got %0d want %0d", acc_a, NPIX); else n_pass++;
    n_total++; if (acc_b != NPIX) $display("FAIL b2b frame2 accepted: got %0d want %0d", acc_b, NPIX); else n_pass++;
    n_total++; if (g_fd != 2) $display("FAIL b2b frame_done pulses: got %0d want 2", g_fd); else n_pass++;
    n_total++; if (g_fd_bad != 0) $display("FAIL b2b frame_done timing: got %0d misplaced want 0", g_fd_bad); else n_pass++;
    f2 = (first_q.size() > 1) ? first_q[1] : -1;
    n_total++; if (f2 != t_b + 1) $display("FAIL b2b frame2 beat0 cycle: got %0d want %0d", f2, t_b + 1); else n_pass++;
`ifdef NEURON_FEEDER_PINGPONG_EN
    n_total++; if (g_inready_lo_f1 != 0) $display("FAIL b2b in_ready low during frame1: got %0d cycles want 0", g_inready_lo_f1); else n_pass++;
`else
    n_total++; if (g_inready_hi != 0) $display("FAIL b2b in_ready during stream: got %0d cycles want 0", g_inready_hi); else n_pass++;
`endif
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b beat count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL b2b beat %0d: got beat=%0d f=%b l=%b pix=%h want beat=%0d f=%b l=%b pix=%h", e.beat, o.beat, o.first, o.last, o.pix, e.beat, e.first, e.last, e.pix);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_random_valid();
    test_reset_load();
    test_reset_stream();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/neuron_batch_feeder.md
Name: neuron_batch_feeder

Overview:
- Producer side of the neuron MAC-lane input bus.
- Accepts one image as a raster-order pixel stream with a valid/ready handshake and buffers the full frame.
- Replays the frame as 49 beats of 16 parallel pixel lanes. Lane i carries pixel i*BATCH_SIZE+beat, matching the per-accumulator slicing of the neuron.
- Also emits the beat index, which downstream uses as the weight-memory address.

Parameters:
NUM_INPUTS, 784, pixels per frame
PIXEL_WIDTH, 10, bits per pixel (unsigned integer)
NUM_LANES, 16, parallel pixel lanes (one per accumulator)
BATCH_SIZE, 49, beats per frame; NUM_LANES*BATCH_SIZE must equal NUM_INPUTS
BEAT_WIDTH, 6, width of beat index, clog2(BATCH_SIZE)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_pixel  in  PIXEL_WIDTH  input pixel, raster order
in_valid  in  1  in_pixel valid
in_ready  out  1  feeder accepts pixel this cycle
out_pixels  out  NUM_LANES*PIXEL_WIDTH  lane i at [i*PIXEL_WIDTH +: PIXEL_WIDTH]
out_beat  out  BEAT_WIDTH  current beat index 0..BATCH_SIZE-1
out_first  out  1  high with beat 0
out_last  out  1  high with beat BATCH_SIZE-1
out_valid  out  1  beat valid
out_ready  in  1  consumer accepts beat
frame_done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Only clk/rst; every register is reset synchronously by rst.
- Reset values:
  - in_ready=1, out_valid=0, out_first=0, out_last=0, frame_done=0, out_beat=0, out_pixels=0.
  - Load counter and beat counter = 0; FSM = LOAD.
  - Pixel buffer contents are don't-care.
- FSM states: LOAD, STREAM.
  - LOAD: in_ready=1. Each in_valid&&in_ready stores in_pixel at buffer[load_cnt] and increments load_cnt.
  - On acceptance of pixel NUM_INPUTS-1: load_cnt wraps to 0 and FSM goes to STREAM next cycle. in_ready drops in that same next cycle.
  - STREAM: out_valid=1. out_pixels lane i = buffer[i*BATCH_SIZE+beat_cnt]; out_beat=beat_cnt.
  - out_first = (beat_cnt==0); out_last = (beat_cnt==BATCH_SIZE-1).
- Latency: last pixel accepted at cycle N -> out_valid=1 with beat 0 at cycle N+1.
- Handshake rules:
  - A beat transfers when out_valid&&out_ready.
  - While out_valid&&!out_ready, out_pixels, out_beat, out_first and out_last hold stable.
  - out_valid never drops before transfer, except on rst.
  - in_valid is sampled only when in_ready=1. Gaps in in_valid are allowed; the count advances only on handshake.
- Last beat transfer at cycle M:
  - Cycle M+1: FSM=LOAD, out_valid=0, in_ready=1, frame_done=1.
  - Cycle M+2: frame_done=0.
  - beat_cnt wraps to 0.
- Throughput: one beat per cycle when out_ready is held high, so 49 cycles per frame stream.
- Outputs come from registered state/counters; no combinational path from in_valid to out_*.
- Widths: counters saturate-free; load_cnt is clog2(NUM_INPUTS) bits. Compares are exact equality to the terminal value.
- rst mid-LOAD: partial frame discarded; next accepted pixel is pixel 0.
- rst mid-STREAM: out_valid=0 the next cycle; no frame_done pulse; remaining beats are dropped.
- out_ready asserted while out_valid=0: ignored.

Optional Feature:
- Macro: NEURON_FEEDER_PINGPONG_EN.
- Defined: two frame buffers (bank A/B) plus per-bank full flags.
  - Loading fills the load bank while the other bank streams.
  - in_ready=0 only when the load bank is full and the stream bank has not finished.
  - Completed load bank starts streaming the cycle after both conditions hold: it is full and the streamer is idle or finishing its last beat.
  - Frames are emitted strictly in arrival order.
  - frame_done timing per frame is unchanged.
- Undefined: single buffer; in_ready=0 for the whole STREAM state as above.

Test Plan:
1. Pixel k = k (0..783), in_valid=1, out_ready=1:
   - Beat 0 lanes = 0,49,98,…,735 with out_first=1.
   - Beat 48 lanes = 48,97,…,783 with out_last=1.
   - frame_done exactly 1 cycle after beat 48.
   - out_valid first rises 1 cycle after pixel 783 accepted.
2. Backpressure: out_ready=0 for 5 cycles while out_beat=10:
   - out_pixels and out_beat stay 10 and stable.
   - Exactly 49 handshakes total, no repeated or skipped beat.
3. in_valid random 50% duty:
   - Exactly 784 pixels accepted; same lane data as test 1.
   - in_ready=0 throughout STREAM (macro undefined).
4. rst after 400 pixels accepted, then a fresh frame with pixel k = 1023-k:
   - in_ready=1 and out_valid=0 after reset.
   - Beat 0 lane 0 = 1023.
5. rst during STREAM at beat 20:
   - Next cycle out_valid=0 and frame_done never pulses.
   - Following frame streams from beat 0.
6. NEURON_FEEDER_PINGPONG_EN defined, two frames back-to-back, out_ready=1:
   - in_ready stays 1 while frame 1 streams.
   - Frame 2 beat 0 appears 1 cycle after its last pixel.
   - Frame order preserved; frame_done pulses twice.
